// File: rtl/reg_file_scoreboard_pkg.sv
// rtl/reg_file_scoreboard_pkg.sv - shared constants and register-ID decode helper
// Purpose: geometry of the register file plus a 4-to-16 wordline decode.
// Ports: none (package).
package reg_file_scoreboard_pkg;

  localparam int NUM_REGS = 16;
  localparam int REG_ID_W = 4;
  localparam int DATA_W   = 16;
  localparam int CNT_W    = 2;
  localparam logic [CNT_W-1:0]    CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [REG_ID_W-1:0] ZERO_REG = 4'd0;

  // Wordline decode of a register ID. Row 0 is hardwired zero, so its
  // wordline is dropped here: an ID of zero selects nothing.
  function automatic logic [NUM_REGS-1:1] decode_nonzero(input logic [REG_ID_W-1:0] id,
                                                        input logic                en);
    logic [NUM_REGS-1:1] sel;
    sel = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      sel[i] = en && (id == REG_ID_W'(i));
    end
    return sel;
  endfunction

endpackage

// File: rtl/reg_file_scoreboard_if.sv
// rtl/reg_file_scoreboard_if.sv - decode/writeback bus of the register file scoreboard
// Purpose: bundles read, writeback and issue signals.
// Ports (slave view): SrcReg1/2, WriteReg, DstReg, DstData, IssueValid, IssueDst in;
//                     SrcData1/2, IssueReady, Hazard, ScbErr out.
interface reg_file_scoreboard_if #(parameter int DATA_W = 16);
  import reg_file_scoreboard_pkg::REG_ID_W;

  logic [REG_ID_W-1:0] SrcReg1;
  logic [REG_ID_W-1:0] SrcReg2;
  logic [DATA_W-1:0]   SrcData1;
  logic [DATA_W-1:0]   SrcData2;
  logic                WriteReg;
  logic [REG_ID_W-1:0] DstReg;
  logic [DATA_W-1:0]   DstData;
  logic                IssueValid;
  logic [REG_ID_W-1:0] IssueDst;
  logic                IssueReady;
  logic                Hazard;
  logic                ScbErr;

  modport master (
    output SrcReg1, SrcReg2, WriteReg, DstReg, DstData, IssueValid, IssueDst,
    input  SrcData1, SrcData2, IssueReady, Hazard, ScbErr
  );

  modport slave (
    input  SrcReg1, SrcReg2, WriteReg, DstReg, DstData, IssueValid, IssueDst,
    output SrcData1, SrcData2, IssueReady, Hazard, ScbErr
  );
endinterface

// File: rtl/reg_file_scoreboard_reg_row.sv
// rtl/reg_file_scoreboard_reg_row.sv - one register plus its pending-write counter
// Purpose: storage row of the register file.
// Ports: clk, rst; i_wr_en/i_wr_data write the register; i_inc/i_dec move the
//        pending counter; o_data/o_pend expose the stored value and count.
module reg_file_scoreboard_reg_row #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_inc,
  input  logic              i_dec,
  output logic [DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]  o_pend
);

  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_pend <= '0;
    end else begin
      if (i_wr_en) begin
        r_data <= i_wr_data;
      end
      // Saturation guards keep the counter from wrapping even if a caller
      // drives inc at max or dec at zero.
      if (i_inc && !i_dec && (r_pend != {CNT_W{1'b1}})) begin
        r_pend <= r_pend + CNT_W'(1);
      end else if (i_dec && !i_inc && (r_pend != '0)) begin
        r_pend <= r_pend - CNT_W'(1);
      end
    end
  end

  assign o_data = r_data;
  assign o_pend = r_pend;

endmodule

// File: rtl/reg_file_scoreboard.sv
// rtl/reg_file_scoreboard.sv - 16x16 register file with pending-write scoreboard
// Purpose: two combinational read ports with write-through bypass, one write
//          port, per-register outstanding-write counters, hazard and error flags.
// Ports: clk, rst (sync, active high); bus (slave modport) carries read, writeback
//        and issue signals.
module reg_file_scoreboard #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  reg_file_scoreboard_if.slave bus
);
  import reg_file_scoreboard_pkg::*;

  localparam logic [CNT_W-1:0] L_CNT_MAX = {CNT_W{1'b1}};

  logic [NUM_REGS-1:1] w_wr_sel;
  logic [NUM_REGS-1:1] w_rd1_sel;
  logic [NUM_REGS-1:1] w_rd2_sel;
  logic [NUM_REGS-1:1] w_iss_sel;
  logic [NUM_REGS-1:1] w_inc;
  logic [NUM_REGS-1:1] w_dec;
  logic [NUM_REGS-1:1] w_pend_nz;
  logic [DATA_W-1:0]   w_data [1:NUM_REGS-1];
  logic [CNT_W-1:0]    w_pend [1:NUM_REGS-1];
  logic [DATA_W-1:0]   w_rd1_mux;
  logic [DATA_W-1:0]   w_rd2_mux;
  logic [CNT_W-1:0]    w_pend_src1;
  logic [CNT_W-1:0]    w_pend_src2;
  logic [CNT_W-1:0]    w_pend_dst;
  logic [CNT_W-1:0]    w_pend_iss;
  logic                w_byp1;
  logic                w_byp2;
  logic                w_haz1;
  logic                w_haz2;
  logic                w_issue_ready;
  logic                r_scb_err;

  // Row 0 has no storage: its wordlines are never decoded, so reads of R0
  // fall out of the one-hot mux as zero and writes/issues to R0 touch nothing.
  assign w_wr_sel  = decode_nonzero(bus.DstReg, bus.WriteReg);
  assign w_rd1_sel = decode_nonzero(bus.SrcReg1, 1'b1);
  assign w_rd2_sel = decode_nonzero(bus.SrcReg2, 1'b1);
  assign w_iss_sel = decode_nonzero(bus.IssueDst, bus.IssueValid);

  always_comb begin
    w_rd1_mux   = '0;
    w_rd2_mux   = '0;
    w_pend_src1 = '0;
    w_pend_src2 = '0;
    w_pend_dst  = '0;
    w_pend_iss  = '0;
    w_pend_nz   = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      w_rd1_mux   = w_rd1_mux   | (w_data[r] & {DATA_W{w_rd1_sel[r]}});
      w_rd2_mux   = w_rd2_mux   | (w_data[r] & {DATA_W{w_rd2_sel[r]}});
      w_pend_src1 = w_pend_src1 | (w_pend[r] & {CNT_W{w_rd1_sel[r]}});
      w_pend_src2 = w_pend_src2 | (w_pend[r] & {CNT_W{w_rd2_sel[r]}});
      w_pend_dst  = w_pend_dst  | (w_pend[r] & {CNT_W{w_wr_sel[r]}});
      w_pend_iss  = w_pend_iss  | (w_pend[r] & {CNT_W{w_iss_sel[r]}});
      w_pend_nz[r] = |w_pend[r];
    end
  end

  // A saturated destination can still accept an issue when a writeback to the
  // same register retires one slot in the same cycle (net count unchanged).
  assign w_issue_ready = !((|w_iss_sel) && (w_pend_iss == L_CNT_MAX) &&
                           !(bus.WriteReg && (bus.DstReg == bus.IssueDst)));

  assign w_inc = w_iss_sel & {(NUM_REGS-1){w_issue_ready}};
  assign w_dec = w_wr_sel & w_pend_nz;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_row
    reg_file_scoreboard_reg_row #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_row (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_wr_sel[r]),
      .i_wr_data (bus.DstData),
      .i_inc     (w_inc[r]),
      .i_dec     (w_dec[r]),
      .o_data    (w_data[r]),
      .o_pend    (w_pend[r])
    );
  end

  // Bypass only for nonzero sources; R0 must stay zero even if written.
  assign w_byp1 = (|w_rd1_sel) && bus.WriteReg && (bus.DstReg == bus.SrcReg1);
  assign w_byp2 = (|w_rd2_sel) && bus.WriteReg && (bus.DstReg == bus.SrcReg2);

  assign bus.SrcData1 = w_byp1 ? bus.DstData : w_rd1_mux;
  assign bus.SrcData2 = w_byp2 ? bus.DstData : w_rd2_mux;

  // Outstanding count minus a retiring write: hazard unless the only pending
  // write is the one being bypassed right now.
  assign w_haz1 = (w_pend_src1 != '0) && !(w_byp1 && (w_pend_src1 == CNT_W'(1)));
  assign w_haz2 = (w_pend_src2 != '0) && !(w_byp2 && (w_pend_src2 == CNT_W'(1)));

  assign bus.Hazard     = w_haz1 || w_haz2;
  assign bus.IssueReady = w_issue_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scb_err <= 1'b0;
    end else if ((|w_wr_sel) && (w_pend_dst == '0)) begin
      r_scb_err <= 1'b1;
    end
  end

  assign bus.ScbErr = r_scb_err;

endmodule
